// File: rtl/output_potential_accumulator_if.sv
// -----------------------------------------------------------------------------
// output_potential_accumulator_if
//
// Bundles the step/current input and potential/valid output of the output
// potential accumulator.
//
// Signals:
//   i_start              - begin a new sample (clear accumulators and step count)
//   i_step_valid         - one timestep's currents are present this cycle
//   i_step_currents_flat - signed currents, neuron k at [(k+1)*IN_W-1 -: IN_W]
//   o_busy               - accumulator is in a sample (ACCUM or EMIT)
//   o_valid              - one-cycle pulse, potentials are final
//   o_potentials_flat    - signed potentials, neuron k at [(k+1)*DATA_W-1 -: DATA_W]
//   o_sat                - sticky: some accumulator clamped during this sample
//
// Modports:
//   master - the current source (SNN engine side) that drives steps
//   slave  - the accumulator itself
// -----------------------------------------------------------------------------
interface output_potential_accumulator_if #(
    parameter int VEC_LEN = 3,
    parameter int DATA_W  = 32,
    parameter int IN_W    = 16
) ();

    logic                      i_start;
    logic                      i_step_valid;
    logic [VEC_LEN*IN_W-1:0]   i_step_currents_flat;
    logic                      o_busy;
    logic                      o_valid;
    logic [VEC_LEN*DATA_W-1:0] o_potentials_flat;
    logic                      o_sat;

    modport master (
        output i_start,
        output i_step_valid,
        output i_step_currents_flat,
        input  o_busy,
        input  o_valid,
        input  o_potentials_flat,
        input  o_sat
    );

    modport slave (
        input  i_start,
        input  i_step_valid,
        input  i_step_currents_flat,
        output o_busy,
        output o_valid,
        output o_potentials_flat,
        output o_sat
    );

endinterface

// File: rtl/output_potential_accumulator.sv
// -----------------------------------------------------------------------------
// output_potential_accumulator
//
// Integrates per-timestep output-layer currents into one signed DATA_W-bit
// membrane potential per output neuron over a window of T_STEPS accepted
// steps, then raises o_valid for exactly one cycle. Additions saturate to the
// signed DATA_W range so a downstream argmax never sees a sign-flipped winner;
// any clamp during the sample sets the sticky o_sat flag.
//
// Parameters:
//   VEC_LEN - number of output neurons
//   DATA_W  - accumulator / potential width (signed)
//   IN_W    - per-step current width (signed), IN_W <= DATA_W
//   T_STEPS - accepted steps per sample, >= 1
//
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - output_potential_accumulator_if.slave (start/step in, potentials out)
//
// Behaviour summary:
//   IDLE  : i_start clears accumulators, count and o_sat, enters ACCUM.
//   ACCUM : each i_step_valid adds the currents; the T_STEPS-th step enters
//           EMIT. i_start restarts the sample and wins over i_step_valid.
//   EMIT  : o_valid high for this one cycle, then IDLE. i_start is ignored.
// Potentials are driven straight from the accumulator registers and hold
// through IDLE until the next i_start.
// -----------------------------------------------------------------------------
module output_potential_accumulator #(
    parameter int VEC_LEN = 3,
    parameter int DATA_W  = 32,
    parameter int IN_W    = 16,
    parameter int T_STEPS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    output_potential_accumulator_if.slave bus
);

    localparam int CNT_W = $clog2(T_STEPS + 1);
    // Count value held while the final step of the window is being accepted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(T_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Saturating add of a sign-extended current to an accumulator.
    // Returns {clamped, result}. The sum is formed one bit wider than the
    // accumulator; the top two bits disagreeing means the true sum left the
    // signed DATA_W range, and the top bit then gives the direction.
    function automatic logic [DATA_W:0] sat_add(
        input logic [DATA_W-1:0] acc,
        input logic [IN_W-1:0]   cur
    );
        logic [DATA_W:0] sum;
        logic [DATA_W:0] res;
        sum = {acc[DATA_W-1], acc} + {{(DATA_W + 1 - IN_W){cur[IN_W-1]}}, cur};
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            if (sum[DATA_W]) begin
                res = {1'b1, 1'b1, {(DATA_W - 1){1'b0}}};
            end else begin
                res = {1'b1, 1'b0, {(DATA_W - 1){1'b1}}};
            end
        end else begin
            res = {1'b0, sum[DATA_W-1:0]};
        end
        return res;
    endfunction

    state_t                    state_r;
    state_t                    state_next_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_next_s;
    logic [VEC_LEN*DATA_W-1:0] acc_r;
    logic [VEC_LEN*DATA_W-1:0] acc_next_s;
    logic                      sat_r;
    logic                      sat_next_s;
    logic                      busy_r;
    logic                      busy_next_s;
    logic                      valid_r;
    logic                      valid_next_s;

    logic [DATA_W:0]           lane_res_s [VEC_LEN];
    logic                      any_clamp_s;
    logic                      clear_s;
    logic                      step_accept_s;
    logic                      last_step_s;

    // Start clears the sample in IDLE and ACCUM; in EMIT it is dropped.
    assign clear_s       = bus.i_start && ((state_r == ST_IDLE) || (state_r == ST_ACCUM));
    // A step counts only in ACCUM and only when no restart shares the cycle.
    assign step_accept_s = (state_r == ST_ACCUM) && !bus.i_start && bus.i_step_valid;
    assign last_step_s   = step_accept_s && (cnt_r == LAST_CNT);

    // Per-lane saturating sums of the current accumulators and input currents.
    always_comb begin
        any_clamp_s = 1'b0;
        for (int k = 0; k < VEC_LEN; k++) begin
            lane_res_s[k] = sat_add(acc_r[k*DATA_W +: DATA_W], bus.i_step_currents_flat[k*IN_W +: IN_W]);
            any_clamp_s   = any_clamp_s | lane_res_s[k][DATA_W];
        end
    end

    // State register plus the registered busy/valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= busy_next_s;
            valid_r <= valid_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_step_s) begin
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_EMIT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode, evaluated on the next state so busy/valid can be
    // registered yet line up with the state they describe.
    always_comb begin
        busy_next_s  = 1'b0;
        valid_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s  = 1'b0;
                valid_next_s = 1'b0;
            end
            ST_ACCUM: begin
                busy_next_s  = 1'b1;
                valid_next_s = 1'b0;
            end
            ST_EMIT: begin
                busy_next_s  = 1'b1;
                valid_next_s = 1'b1;
            end
            default: begin
                busy_next_s  = 1'b0;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: clear on start, accumulate on an accepted step,
    // otherwise hold (potentials stay visible through IDLE).
    always_comb begin
        acc_next_s = acc_r;
        cnt_next_s = cnt_r;
        sat_next_s = sat_r;
        if (clear_s) begin
            acc_next_s = {(VEC_LEN * DATA_W){1'b0}};
            cnt_next_s = {CNT_W{1'b0}};
            sat_next_s = 1'b0;
        end else if (step_accept_s) begin
            for (int k = 0; k < VEC_LEN; k++) begin
                acc_next_s[k*DATA_W +: DATA_W] = lane_res_s[k][DATA_W-1:0];
            end
            cnt_next_s = cnt_r + CNT_ONE;
            sat_next_s = sat_r | any_clamp_s;
        end else begin
            acc_next_s = acc_r;
            cnt_next_s = cnt_r;
            sat_next_s = sat_r;
        end
    end

    // Accumulator, step counter and sticky saturation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {(VEC_LEN * DATA_W){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            sat_r <= 1'b0;
        end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            sat_r <= sat_next_s;
        end
    end

    assign bus.o_potentials_flat = acc_r;
    assign bus.o_sat             = sat_r;
    assign bus.o_busy            = busy_r;
    assign bus.o_valid           = valid_r;

endmodule
